// File: rtl/lc3_control_fsm_pkg.sv
// Shared types for the eLC-3 control unit: state encoding, opcodes,
// mux/ALU encodings and the packed control word driven to the datapath.
package lc3_ctrl_pkg;

    typedef enum logic [5:0] {
        S_HALT, S_F1, S_F2, S_F3, S_DEC,
        S_ADD, S_AND, S_NOT,
        S_BR0, S_BR1, S_JMP,
        S_J0, S_JSR1, S_JSRR1,
        S_LD0, S_LDR0, S_LD1, S_LD2,
        S_LDI0, S_LDI1, S_LDI2, S_LDI3,
        S_ST0, S_STR0, S_ST1, S_ST2,
        S_STI0, S_STI1, S_STI2,
        S_T0, S_T1, S_T2, S_T3,
        S_PS0, S_PS1
    } state_e;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_LD    = 4'b0010;
    localparam logic [3:0] OP_ST    = 4'b0011;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_RTI   = 4'b1000;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_LDI   = 4'b1010;
    localparam logic [3:0] OP_STI   = 4'b1011;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_LEA   = 4'b1110;
    localparam logic [3:0] OP_TRAP  = 4'b1111;

    localparam logic [1:0] PCMUX_INC   = 2'd0;
    localparam logic [1:0] PCMUX_BUS   = 2'd1;
    localparam logic [1:0] PCMUX_ADDR  = 2'd2;
    localparam logic [1:0] DRMUX_IR119 = 2'd0;
    localparam logic [1:0] DRMUX_R7    = 2'd1;
    localparam logic [1:0] SR1_IR119   = 2'd0;
    localparam logic [1:0] SR1_IR86    = 2'd1;
    localparam logic [1:0] A2_ZERO     = 2'd0;
    localparam logic [1:0] A2_OFF6     = 2'd1;
    localparam logic [1:0] A2_OFF9     = 2'd2;
    localparam logic [1:0] A2_OFF11    = 2'd3;
    localparam logic [1:0] ALUK_ADD    = 2'd0;
    localparam logic [1:0] ALUK_AND    = 2'd1;
    localparam logic [1:0] ALUK_NOT    = 2'd2;
    localparam logic [1:0] ALUK_PASS   = 2'd3;
    localparam logic       A1_PC       = 1'b0;
    localparam logic       A1_SR1      = 1'b1;
    localparam logic       MARMUX_ZEXT = 1'b0;
    localparam logic       MARMUX_ADDR = 1'b1;

    typedef struct packed {
        logic       paused;
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       addr1mux, sr2mux, marmux;
        logic [1:0] addr2mux, pcmux, drmux, sr1mux, aluk;
        logic       mio_en, mem_ce, mem_oe, mem_we;
    } ctrl_t;

    // States that hold until the RAM signals completion.
    function automatic logic mem_state(state_e s);
        return s inside {S_F2, S_LD1, S_LDI1, S_LDI3, S_STI1, S_T2, S_ST2};
    endfunction

endpackage

// File: rtl/lc3_control_fsm_if.sv
// Control-unit boundary: top-level switches, IR/BEN feedback, RAM handshake
// inputs and every datapath control output.
interface lc3_control_fsm_if;
    logic       Run, Continue;
    logic [3:0] IR_15_12;
    logic       IR_11, IR_5, BEN, Mem_R;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic       ADDR1MUX, SR2MUX, MARMUX;
    logic [1:0] ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK;
    logic       MIO_EN, Mem_CE, Mem_OE, Mem_WE, Paused;

    modport master (
        input  Run, Continue, IR_15_12, IR_11, IR_5, BEN, Mem_R,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
               GatePC, GateMDR, GateALU, GateMARMUX,
               ADDR1MUX, SR2MUX, MARMUX, ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK,
               MIO_EN, Mem_CE, Mem_OE, Mem_WE, Paused
    );

    modport slave (
        output Run, Continue, IR_15_12, IR_11, IR_5, BEN, Mem_R,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
               GatePC, GateMDR, GateALU, GateMARMUX,
               ADDR1MUX, SR2MUX, MARMUX, ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK,
               MIO_EN, Mem_CE, Mem_OE, Mem_WE, Paused
    );
endinterface

// File: rtl/lc3_control_fsm_decode.sv
// State-to-control-word table. Everything defaults to 0; each state raises
// only what its datapath transfer needs. SR2MUX follows IR[5] in ADD/AND.
module lc3_ctrl_decode
    import lc3_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   ir_5_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_HALT, S_PS0, S_PS1: ctrl_o.paused = 1'b1;
            S_F1: begin
                ctrl_o.ld_mar   = 1'b1;
                ctrl_o.gate_pc  = 1'b1;
                ctrl_o.pcmux    = PCMUX_ADDR;
                ctrl_o.addr1mux = A1_PC;
                ctrl_o.addr2mux = A2_ZERO;
            end
            S_F2, S_LD1, S_LDI1, S_LDI3, S_STI1, S_T2: begin
                ctrl_o.mem_ce = 1'b1;
                ctrl_o.mem_oe = 1'b1;
                ctrl_o.mio_en = 1'b1;
                ctrl_o.ld_mdr = 1'b1;
            end
            // RAM output is routed straight onto the bus whenever GateMDR is up.
            S_F3, S_LD2, S_LDI2, S_STI2, S_T3: begin
                ctrl_o.gate_mdr = 1'b1;
                ctrl_o.mio_en   = 1'b1;
                ctrl_o.mem_ce   = 1'b1;
                ctrl_o.mem_oe   = 1'b1;
                ctrl_o.ld_ir    = (state_i == S_F3);
                ctrl_o.ld_pc    = (state_i == S_F3) || (state_i == S_T3);
                ctrl_o.pcmux    = (state_i == S_T3) ? PCMUX_BUS : PCMUX_INC;
                ctrl_o.ld_reg   = (state_i == S_LD2);
                ctrl_o.ld_cc    = (state_i == S_LD2);
                ctrl_o.drmux    = DRMUX_IR119;
                ctrl_o.ld_mar   = (state_i == S_LDI2) || (state_i == S_STI2);
            end
            S_DEC: ctrl_o.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                ctrl_o.ld_reg   = 1'b1;
                ctrl_o.ld_cc    = 1'b1;
                ctrl_o.gate_alu = 1'b1;
                ctrl_o.drmux    = DRMUX_IR119;
                ctrl_o.sr1mux   = SR1_IR86;
                ctrl_o.sr2mux   = (state_i != S_NOT) && ir_5_i;
                ctrl_o.aluk     = (state_i == S_ADD) ? ALUK_ADD :
                                  (state_i == S_AND) ? ALUK_AND : ALUK_NOT;
            end
            S_BR1, S_JSR1: begin
                ctrl_o.ld_pc    = 1'b1;
                ctrl_o.pcmux    = PCMUX_ADDR;
                ctrl_o.addr1mux = A1_PC;
                ctrl_o.addr2mux = (state_i == S_BR1) ? A2_OFF9 : A2_OFF11;
            end
            S_JMP, S_JSRR1: begin
                ctrl_o.ld_pc    = 1'b1;
                ctrl_o.pcmux    = PCMUX_ADDR;
                ctrl_o.addr1mux = A1_SR1;
                ctrl_o.sr1mux   = SR1_IR86;
                ctrl_o.addr2mux = A2_ZERO;
            end
            S_J0, S_T0: begin
                ctrl_o.gate_pc  = 1'b1;
                ctrl_o.pcmux    = PCMUX_ADDR;
                ctrl_o.addr1mux = A1_PC;
                ctrl_o.addr2mux = A2_ZERO;
                ctrl_o.ld_reg   = 1'b1;
                ctrl_o.drmux    = DRMUX_R7;
            end
            S_LD0, S_LDI0, S_ST0, S_STI0: begin
                ctrl_o.ld_mar      = 1'b1;
                ctrl_o.gate_marmux = 1'b1;
                ctrl_o.marmux      = MARMUX_ADDR;
                ctrl_o.addr1mux    = A1_PC;
                ctrl_o.addr2mux    = A2_OFF9;
            end
            S_LDR0, S_STR0: begin
                ctrl_o.ld_mar      = 1'b1;
                ctrl_o.gate_marmux = 1'b1;
                ctrl_o.marmux      = MARMUX_ADDR;
                ctrl_o.addr1mux    = A1_SR1;
                ctrl_o.sr1mux      = SR1_IR86;
                ctrl_o.addr2mux    = A2_OFF6;
            end
            // Store data goes through the ALU, never from RAM.
            S_ST1: begin
                ctrl_o.gate_alu = 1'b1;
                ctrl_o.aluk     = ALUK_PASS;
                ctrl_o.sr1mux   = SR1_IR119;
                ctrl_o.mio_en   = 1'b0;
                ctrl_o.ld_mdr   = 1'b1;
            end
            S_ST2: begin
                ctrl_o.mem_ce = 1'b1;
                ctrl_o.mem_we = 1'b1;
            end
            S_T1: begin
                ctrl_o.ld_mar      = 1'b1;
                ctrl_o.gate_marmux = 1'b1;
                ctrl_o.marmux      = MARMUX_ZEXT;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lc3_control_fsm.sv
// eLC-3 control unit: state register and next-state logic; the control word
// is decoded from the registered state only.
module lc3_control_fsm
    import lc3_ctrl_pkg::*;
#(
    parameter logic [3:0] PAUSE_OP = OP_PAUSE
) (
    input  logic                  Clk,
    input  logic                  Reset,
    lc3_control_fsm_if.master     bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = state_q;
        if (!mem_state(state_q) || bus.Mem_R) begin
            case (state_q)
                S_HALT:  state_d = bus.Run ? S_F1 : S_HALT;
                S_F1:    state_d = S_F2;
                S_F2:    state_d = S_F3;
                S_F3:    state_d = S_DEC;
                S_DEC: begin
                    if (bus.IR_15_12 == PAUSE_OP) state_d = S_PS0;
                    else begin
                        case (bus.IR_15_12)
                            OP_ADD:  state_d = S_ADD;
                            OP_AND:  state_d = S_AND;
                            OP_NOT:  state_d = S_NOT;
                            OP_BR:   state_d = S_BR0;
                            OP_JMP:  state_d = S_JMP;
                            OP_JSR:  state_d = S_J0;
                            OP_LD:   state_d = S_LD0;
                            OP_LDR:  state_d = S_LDR0;
                            OP_LDI:  state_d = S_LDI0;
                            OP_ST:   state_d = S_ST0;
                            OP_STR:  state_d = S_STR0;
                            OP_STI:  state_d = S_STI0;
                            OP_TRAP: state_d = S_T0;
                            OP_RTI, OP_LEA: state_d = S_F1;
                            default: state_d = S_F1;
                        endcase
                    end
                end
                S_BR0:   state_d = bus.BEN ? S_BR1 : S_F1;
                S_J0:    state_d = bus.IR_11 ? S_JSR1 : S_JSRR1;
                S_LD0, S_LDR0:  state_d = S_LD1;
                S_LD1:   state_d = S_LD2;
                S_LDI0:  state_d = S_LDI1;
                S_LDI1:  state_d = S_LDI2;
                S_LDI2:  state_d = S_LDI3;
                S_LDI3:  state_d = S_LD2;
                S_ST0, S_STR0:  state_d = S_ST1;
                S_STI0:  state_d = S_STI1;
                S_STI1:  state_d = S_STI2;
                S_STI2:  state_d = S_ST1;
                S_ST1:   state_d = S_ST2;
                S_T0:    state_d = S_T1;
                S_T1:    state_d = S_T2;
                S_T2:    state_d = S_T3;
                S_PS0:   state_d = bus.Continue ? S_PS1 : S_PS0;
                S_PS1:   state_d = bus.Continue ? S_PS1 : S_F1;
                default: state_d = S_F1;
            endcase
        end
    end

    // Async reset drops any in-flight RAM strobe at once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= S_HALT;
        else        state_q <= state_d;
    end

    lc3_ctrl_decode u_decode (
        .state_i (state_q),
        .ir_5_i  (bus.IR_5),
        .ctrl_o  (ctrl)
    );

    assign bus.LD_MAR     = ctrl.ld_mar;
    assign bus.LD_MDR     = ctrl.ld_mdr;
    assign bus.LD_IR      = ctrl.ld_ir;
    assign bus.LD_BEN     = ctrl.ld_ben;
    assign bus.LD_REG     = ctrl.ld_reg;
    assign bus.LD_CC      = ctrl.ld_cc;
    assign bus.LD_PC      = ctrl.ld_pc;
    assign bus.GatePC     = ctrl.gate_pc;
    assign bus.GateMDR    = ctrl.gate_mdr;
    assign bus.GateALU    = ctrl.gate_alu;
    assign bus.GateMARMUX = ctrl.gate_marmux;
    assign bus.ADDR1MUX   = ctrl.addr1mux;
    assign bus.SR2MUX     = ctrl.sr2mux;
    assign bus.MARMUX     = ctrl.marmux;
    assign bus.ADDR2MUX   = ctrl.addr2mux;
    assign bus.PCMUX      = ctrl.pcmux;
    assign bus.DRMUX      = ctrl.drmux;
    assign bus.SR1MUX     = ctrl.sr1mux;
    assign bus.ALUK       = ctrl.aluk;
    assign bus.MIO_EN     = ctrl.mio_en;
    assign bus.Mem_CE     = ctrl.mem_ce;
    assign bus.Mem_OE     = ctrl.mem_oe;
    assign bus.Mem_WE     = ctrl.mem_we;
    assign bus.Paused     = ctrl.paused;

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for the eLC-3 control unit: per-cycle expected control words
// are queued as stimulus is driven and checked on the falling edge.
module tb_lc3_control_fsm;

    typedef struct packed {
        logic       paused;
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
        logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic       addr1mux, sr2mux, marmux;
        logic [1:0] addr2mux, pcmux, drmux, sr1mux, aluk;
        logic       mio_en, mem_ce, mem_oe, mem_we;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  v;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;
    obs_t cur;

    lc3_control_fsm_if bus ();

    lc3_control_fsm #(.PAUSE_OP(4'b1101)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    assign cur = {bus.Paused, bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN, bus.LD_REG,
                  bus.LD_CC, bus.LD_PC, bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX,
                  bus.ADDR1MUX, bus.SR2MUX, bus.MARMUX, bus.ADDR2MUX, bus.PCMUX, bus.DRMUX,
                  bus.SR1MUX, bus.ALUK, bus.MIO_EN, bus.Mem_CE, bus.Mem_OE, bus.Mem_WE};

    always @(negedge Clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (cur === e.v) else begin
                errors++;
                $error("FAIL %s got=%h exp=%h", e.tag, cur, e.v);
            end
        end
        if (Reset === 1'b1) begin
            checks++;
            assert (($countones({bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX}) <= 1) === 1'b1) else begin
                errors++;
                $error("FAIL inv_gate got=%b exp=at_most_one",
                       {bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX});
            end
            checks++;
            assert ((!bus.GateMDR || bus.MIO_EN) === 1'b1) else begin
                errors++;
                $error("FAIL inv_mdr_mio got=%b exp=1", bus.MIO_EN);
            end
            checks++;
            assert ((bus.Mem_OE && bus.Mem_WE) === 1'b0) else begin
                errors++;
                $error("FAIL inv_oe_we got=1 exp=0");
            end
        end
    end

    function automatic obs_t o_halt();
        obs_t o = '0; o.paused = 1'b1; return o;
    endfunction
    function automatic obs_t o_f1();
        obs_t o = '0; o.ld_mar = 1'b1; o.gate_pc = 1'b1; o.pcmux = 2'd2; return o;
    endfunction
    function automatic obs_t o_rd();
        obs_t o = '0; o.mem_ce = 1'b1; o.mem_oe = 1'b1; o.mio_en = 1'b1; o.ld_mdr = 1'b1; return o;
    endfunction
    function automatic obs_t o_mdrbus();
        obs_t o = '0; o.gate_mdr = 1'b1; o.mio_en = 1'b1; o.mem_ce = 1'b1; o.mem_oe = 1'b1; return o;
    endfunction
    function automatic obs_t o_r7();
        obs_t o = o_f1(); o.ld_mar = 1'b0; o.ld_reg = 1'b1; o.drmux = 2'd1; return o;
    endfunction

    task automatic cyc(input string tag, input obs_t v, input logic memr);
        exp_t x;
        x.tag = tag;
        x.v   = v;
        bus.Mem_R = memr;
        sb.push_back(x);
        @(posedge Clk);
        #1;
    endtask

    task automatic rd(input string nm, input int waits);
        for (int i = 0; i < waits; i++) cyc({nm, "_wait"}, o_rd(), 1'b0);
        cyc(nm, o_rd(), 1'b1);
    endtask

    task automatic fetch(input string nm, input int waits);
        obs_t o;
        cyc({nm, "_f1"}, o_f1(), 1'b1);
        rd({nm, "_f2"}, waits);
        o = o_mdrbus(); o.ld_ir = 1'b1; o.ld_pc = 1'b1; o.pcmux = 2'd0;
        cyc({nm, "_f3"}, o, 1'b1);
        o = '0; o.ld_ben = 1'b1;
        cyc({nm, "_dec"}, o, 1'b1);
    endtask

    task automatic set_ir(input logic [3:0] op, input logic i11, input logic i5);
        bus.IR_15_12 = op; bus.IR_11 = i11; bus.IR_5 = i5;
    endtask

    initial begin
        obs_t o;
        Reset = 1'b0;
        bus.Run = 1'b0; bus.Continue = 1'b0; bus.BEN = 1'b0; bus.Mem_R = 1'b0;
        set_ir(4'b0000, 1'b0, 1'b0);
        @(posedge Clk);
        #1;
        cyc("rst_halt", o_halt(), 1'b0);
        Reset = 1'b1;
        cyc("halt_idle", o_halt(), 1'b0);
        bus.Run = 1'b1;
        cyc("halt_run", o_halt(), 1'b0);
        bus.Run = 1'b0;

        // Async reset while a fetch read is stalled.
        cyc("pre_f1", o_f1(), 1'b0);
        cyc("pre_f2a", o_rd(), 1'b0);
        cyc("pre_f2b", o_rd(), 1'b0);
        begin
            exp_t x;
            x.tag = "rst_mid_f2"; x.v = o_halt();
            sb.push_back(x);
        end
        #2 Reset = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b1;
        bus.Run = 1'b1;
        cyc("rst_run", o_halt(), 1'b0);
        bus.Run = 1'b0;

        set_ir(4'b0001, 1'b0, 1'b1);
        fetch("add", 0);
        o = '0; o.ld_reg = 1'b1; o.ld_cc = 1'b1; o.gate_alu = 1'b1; o.sr1mux = 2'd1;
        o.sr2mux = 1'b1; o.aluk = 2'd0;
        cyc("add_ex", o, 1'b1);

        set_ir(4'b0101, 1'b0, 1'b0);
        fetch("and", 0);
        o.sr2mux = 1'b0; o.aluk = 2'd1;
        cyc("and_ex", o, 1'b1);

        set_ir(4'b1001, 1'b0, 1'b1);
        fetch("not", 0);
        o.aluk = 2'd2;
        cyc("not_ex", o, 1'b1);

        set_ir(4'b0110, 1'b0, 1'b0);
        fetch("ldr", 3);
        o = '0; o.ld_mar = 1'b1; o.gate_marmux = 1'b1; o.marmux = 1'b1; o.addr1mux = 1'b1;
        o.sr1mux = 2'd1; o.addr2mux = 2'd1;
        cyc("ldr_addr", o, 1'b1);
        rd("ldr_rd", 3);
        o = o_mdrbus(); o.ld_reg = 1'b1; o.ld_cc = 1'b1;
        cyc("ldr_wb", o, 1'b1);

        set_ir(4'b0000, 1'b0, 1'b0);
        bus.BEN = 1'b0;
        fetch("brn", 0);
        cyc("brn_br0", '0, 1'b1);
        bus.BEN = 1'b1;
        fetch("brt", 0);
        cyc("brt_br0", '0, 1'b1);
        o = '0; o.ld_pc = 1'b1; o.pcmux = 2'd2; o.addr2mux = 2'd2;
        cyc("brt_br1", o, 1'b1);
        bus.BEN = 1'b0;

        set_ir(4'b0100, 1'b1, 1'b0);
        fetch("jsr", 0);
        cyc("jsr_r7", o_r7(), 1'b1);
        o = '0; o.ld_pc = 1'b1; o.pcmux = 2'd2; o.addr2mux = 2'd3;
        cyc("jsr_pc", o, 1'b1);

        set_ir(4'b0100, 1'b0, 1'b0);
        fetch("jsrr", 0);
        cyc("jsrr_r7", o_r7(), 1'b1);
        o = '0; o.ld_pc = 1'b1; o.pcmux = 2'd2; o.addr1mux = 1'b1; o.sr1mux = 2'd1;
        cyc("jsrr_pc", o, 1'b1);

        set_ir(4'b0011, 1'b0, 1'b0);
        fetch("st", 0);
        o = '0; o.ld_mar = 1'b1; o.gate_marmux = 1'b1; o.marmux = 1'b1; o.addr2mux = 2'd2;
        cyc("st_addr", o, 1'b1);
        o = '0; o.gate_alu = 1'b1; o.aluk = 2'd3; o.ld_mdr = 1'b1;
        cyc("st_mdr", o, 1'b1);
        o = '0; o.mem_ce = 1'b1; o.mem_we = 1'b1;
        cyc("st_wr_wait", o, 1'b0);
        cyc("st_wr", o, 1'b1);

        set_ir(4'b1111, 1'b0, 1'b1);
        fetch("trap", 0);
        cyc("trap_r7", o_r7(), 1'b1);
        o = '0; o.ld_mar = 1'b1; o.gate_marmux = 1'b1;
        cyc("trap_vec", o, 1'b1);
        rd("trap_rd", 0);
        o = o_mdrbus(); o.ld_pc = 1'b1; o.pcmux = 2'd1;
        cyc("trap_pc", o, 1'b1);

        set_ir(4'b1000, 1'b0, 1'b0);
        fetch("nop", 0);

        set_ir(4'b1101, 1'b0, 1'b0);
        fetch("pause", 0);
        cyc("ps0_hold", o_halt(), 1'b1);
        bus.Continue = 1'b1;
        cyc("ps0_go", o_halt(), 1'b1);
        for (int i = 0; i < 3; i++) cyc("ps1_hold", o_halt(), 1'b1);
        bus.Continue = 1'b0;
        cyc("ps1_rel", o_halt(), 1'b1);
        cyc("end_f1", o_f1(), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
